matmul_sequencer: RTL and testbench

//  Control FSM for the matmul accelerator. On a start request it clears the systolic PE array and streams skewed operand indices into it.
//  It then walks the N x M result grid for write-back and signals completion to the APB control register.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/matmul_sequencer_if.sv | 44 ++++
 rtl/matmul_skew_gen.sv | 35 +++
 rtl/matmul_sequencer.sv | 145 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state encoding and helpers for the matmul sequencer.
package matmul_pkg;

  localparam int unsigned MAX_DIM = 4;
  localparam int unsigned DIM_W   = 2;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WB,
    S_DONE
  } seq_state_e;

  // Feed length K+N+M-2 expressed in the minus-one dimension encoding.
  function automatic logic [CNT_W-1:0] feed_len(input logic [DIM_W-1:0] dn,
                                                input logic [DIM_W-1:0] dk,
                                                input logic [DIM_W-1:0] dm);
    return CNT_W'(dn) + CNT_W'(dk) + CNT_W'(dm) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control/operand bundle between the APB register block and the matmul sequencer.
// perf_cycles_o exists only when MATMUL_SEQ_PERF_CNT_EN is defined.
interface matmul_sequencer_if;
  import matmul_pkg::*;

  logic                       start_i;
  logic [DIM_W-1:0]           dim_n_i;
  logic [DIM_W-1:0]           dim_k_i;
  logic [DIM_W-1:0]           dim_m_i;
  logic                       op_wr_i;
  logic                       busy_o;
  logic                       pe_clr_o;
  logic [MAX_DIM-1:0]         a_vld_o;
  logic [MAX_DIM*DIM_W-1:0]   a_k_o;
  logic [MAX_DIM-1:0]         b_vld_o;
  logic [MAX_DIM*DIM_W-1:0]   b_k_o;
  logic                       res_we_o;
  logic [DIM_W-1:0]           res_row_o;
  logic [DIM_W-1:0]           res_col_o;
  logic                       done_o;
  logic                       err_o;
`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [15:0]                perf_cycles_o;
`endif

  modport master (
    output start_i, dim_n_i, dim_k_i, dim_m_i, op_wr_i,
    input  busy_o, pe_clr_o, a_vld_o, a_k_o, b_vld_o, b_k_o,
    input  res_we_o, res_row_o, res_col_o, done_o, err_o
`ifdef MATMUL_SEQ_PERF_CNT_EN
    , input perf_cycles_o
`endif
  );

  modport slave (
    input  start_i, dim_n_i, dim_k_i, dim_m_i, op_wr_i,
    output busy_o, pe_clr_o, a_vld_o, a_k_o, b_vld_o, b_k_o,
    output res_we_o, res_row_o, res_col_o, done_o, err_o
`ifdef MATMUL_SEQ_PERF_CNT_EN
    , output perf_cycles_o
`endif
  );

endinterface

// File: rtl/matmul_skew_gen.sv
// Combinational operand skew: feed step t plus dimensions -> per-lane valid and k index.
module matmul_skew_gen
  import matmul_pkg::*;
(
  input  logic [CNT_W-1:0]         t_i,
  input  logic [DIM_W-1:0]         dim_n_i,
  input  logic [DIM_W-1:0]         dim_k_i,
  input  logic [DIM_W-1:0]         dim_m_i,
  output logic [MAX_DIM-1:0]       a_vld_o,
  output logic [MAX_DIM*DIM_W-1:0] a_k_o,
  output logic [MAX_DIM-1:0]       b_vld_o,
  output logic [MAX_DIM*DIM_W-1:0] b_k_o
);

  always_comb begin
    a_vld_o = '0;
    a_k_o   = '0;
    b_vld_o = '0;
    b_k_o   = '0;
    for (int l = 0; l < MAX_DIM; l++) begin
      // Lane l lags t by l cycles; it is live while its k index lies in [0, K).
      if (t_i >= CNT_W'(l) && (t_i - CNT_W'(l)) <= CNT_W'(dim_k_i)) begin
        if (DIM_W'(l) <= dim_n_i) begin
          a_vld_o[l]               = 1'b1;
          a_k_o[l*DIM_W +: DIM_W]  = DIM_W'(t_i - CNT_W'(l));
        end
        if (DIM_W'(l) <= dim_m_i) begin
          b_vld_o[l]               = 1'b1;
          b_k_o[l*DIM_W +: DIM_W]  = DIM_W'(t_i - CNT_W'(l));
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Matmul control FSM: clear PEs, stream skewed operand indices, walk results, pulse done.
// Optional cycle counter enabled by MATMUL_SEQ_PERF_CNT_EN.
module matmul_sequencer
  import matmul_pkg::*;
(
  input logic               clk_i,
  input logic               rst_i,
  matmul_sequencer_if.slave bus
);

  seq_state_e               state_q;
  logic [DIM_W-1:0]         dim_n_q, dim_k_q, dim_m_q;
  logic [CNT_W-1:0]         t_q;
  logic [DIM_W-1:0]         row_q, col_q;
  logic                     busy_q, clr_q, we_q, done_q;
  logic [MAX_DIM-1:0]       a_vld_q, b_vld_q;
  logic [MAX_DIM*DIM_W-1:0] a_k_q, b_k_q;
  logic [MAX_DIM-1:0]       a_vld_nxt, b_vld_nxt;
  logic [MAX_DIM*DIM_W-1:0] a_k_nxt, b_k_nxt;

  // t_q runs one step ahead so the skew outputs can be registered.
  matmul_skew_gen u_skew (
    .t_i     (t_q),
    .dim_n_i (dim_n_q),
    .dim_k_i (dim_k_q),
    .dim_m_i (dim_m_q),
    .a_vld_o (a_vld_nxt),
    .a_k_o   (a_k_nxt),
    .b_vld_o (b_vld_nxt),
    .b_k_o   (b_k_nxt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dim_n_q <= '0;
      dim_k_q <= '0;
      dim_m_q <= '0;
      t_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      a_vld_q <= '0;
      a_k_q   <= '0;
      b_vld_q <= '0;
      b_k_q   <= '0;
    end else begin
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      a_vld_q <= '0;
      a_k_q   <= '0;
      b_vld_q <= '0;
      b_k_q   <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_q <= S_CLEAR;
            dim_n_q <= bus.dim_n_i;
            dim_k_q <= bus.dim_k_i;
            dim_m_q <= bus.dim_m_i;
            t_q     <= '0;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q <= S_FEED;
          a_vld_q <= a_vld_nxt;
          a_k_q   <= a_k_nxt;
          b_vld_q <= b_vld_nxt;
          b_k_q   <= b_k_nxt;
          t_q     <= t_q + CNT_W'(1);
        end
        S_FEED: begin
          if (t_q == feed_len(dim_n_q, dim_k_q, dim_m_q)) begin
            state_q <= S_WB;
            t_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b1;
          end else begin
            a_vld_q <= a_vld_nxt;
            a_k_q   <= a_k_nxt;
            b_vld_q <= b_vld_nxt;
            b_k_q   <= b_k_nxt;
            t_q     <= t_q + CNT_W'(1);
          end
        end
        S_WB: begin
          if (col_q == dim_m_q) begin
            col_q <= '0;
            if (row_q == dim_n_q) begin
              state_q <= S_DONE;
              row_q   <= '0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q <= row_q + DIM_W'(1);
            end
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.pe_clr_o  = clr_q;
  assign bus.a_vld_o   = a_vld_q;
  assign bus.a_k_o     = a_k_q;
  assign bus.b_vld_o   = b_vld_q;
  assign bus.b_k_o     = b_k_q;
  assign bus.res_we_o  = we_q;
  assign bus.res_row_o = row_q;
  assign bus.res_col_o = col_q;
  assign bus.done_o    = done_q;
  // Same-cycle flag; the DONE cycle counts as busy.
  assign bus.err_o     = busy_q & (bus.start_i | bus.op_wr_i);

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && bus.start_i) begin
      perf_q <= '0;
    end else if (busy_q && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign bus.perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized and directed bench for matmul_sequencer against a cycle-trace reference model.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_sequencer_if bus();

  matmul_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       clr;
    logic [3:0] av;
    logic [7:0] ak;
    logic [3:0] bv;
    logic [7:0] bk;
    logic       we;
    logic [1:0] row;
    logic [1:0] col;
    logic       done;
  } exp_t;

  exp_t queue_exp[$];
  exp_t e;
  logic busy_now;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_perf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected per-cycle trace of one accepted start, cycle 1 onward.
  task automatic push_run(input int dn, input int dk, input int dm);
    exp_t x;
    int n, k, m;
    n = dn + 1;
    k = dk + 1;
    m = dm + 1;
    x = '0; x.busy = 1'b1; x.clr = 1'b1;
    queue_exp.push_back(x);
    for (int t = 0; t < n + k + m - 2; t++) begin
      x = '0; x.busy = 1'b1;
      for (int l = 0; l < 4; l++) begin
        if (t - l >= 0 && t - l < k) begin
          if (l < n) begin x.av[l] = 1'b1; x.ak[l*2 +: 2] = 2'(t - l); end
          if (l < m) begin x.bv[l] = 1'b1; x.bk[l*2 +: 2] = 2'(t - l); end
        end
      end
      queue_exp.push_back(x);
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        x = '0; x.busy = 1'b1; x.we = 1'b1; x.row = 2'(i); x.col = 2'(j);
        queue_exp.push_back(x);
      end
    x = '0; x.busy = 1'b1; x.done = 1'b1;
    queue_exp.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      e = '0;
      queue_exp.delete();
      exp_perf = 0;
    end else begin
      busy_now = (queue_exp.size() != 0);
      e = busy_now ? queue_exp[0] : '0;
    end
    chk("busy", 32'(bus.busy_o), 32'(e.busy));
    chk("pe_clr", 32'(bus.pe_clr_o), 32'(e.clr));
    chk("a_vld", 32'(bus.a_vld_o), 32'(e.av));
    chk("a_k", 32'(bus.a_k_o), 32'(e.ak));
    chk("b_vld", 32'(bus.b_vld_o), 32'(e.bv));
    chk("b_k", 32'(bus.b_k_o), 32'(e.bk));
    chk("res_we", 32'(bus.res_we_o), 32'(e.we));
    chk("res_row", 32'(bus.res_row_o), 32'(e.row));
    chk("res_col", 32'(bus.res_col_o), 32'(e.col));
    chk("done", 32'(bus.done_o), 32'(e.done));
    chk("err", 32'(bus.err_o),
        32'(!rst && busy_now && (bus.start_i || bus.op_wr_i)));
`ifdef MATMUL_SEQ_PERF_CNT_EN
    chk("perf", 32'(bus.perf_cycles_o), 32'(exp_perf));
`endif
    if (!rst) begin
      if (busy_now) begin
        void'(queue_exp.pop_front());
        if (exp_perf < 16'hFFFF) exp_perf++;
      end else if (bus.start_i) begin
        push_run(int'(bus.dim_n_i), int'(bus.dim_k_i), int'(bus.dim_m_i));
        exp_perf = 0;
      end
    end
  end

  // Start at edge 0; returns the cycle of done_o plus observations along the way.
  task automatic run_dir(input int dn, input int dk, input int dm,
                         input int s_at, input int w_at,
                         output int cyc, output int wr, output int errs,
                         output logic [3:0] or_a, output logic [3:0] or_b,
                         output logic [3:0] av3, output logic [7:0] ak3);
    wr = 0; errs = 0; or_a = '0; or_b = '0; av3 = '0; ak3 = '0;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.dim_n_i = 2'(dn); bus.dim_k_i = 2'(dk); bus.dim_m_i = 2'(dm);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      bus.start_i = (cyc == s_at);
      bus.op_wr_i = (cyc == w_at);
      @(negedge clk);
      if (bus.res_we_o) wr++;
      if (bus.err_o) errs++;
      or_a |= bus.a_vld_o;
      or_b |= bus.b_vld_o;
      if (cyc == 3) begin av3 = bus.a_vld_o; ak3 = bus.a_k_o; end
      if (bus.done_o) break;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_i = 1'b0;
    bus.op_wr_i = 1'b0;
  endtask

  int         cyc, wr, errs, dones;
  logic [3:0] or_a, or_b, av3;
  logic [7:0] ak3;

  initial begin
    bus.start_i = 1'b0; bus.op_wr_i = 1'b0;
    bus.dim_n_i = '0; bus.dim_k_i = '0; bus.dim_m_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle_busy", 32'(bus.busy_o), 32'd0);

    run_dir(0, 0, 0, 0, 0, cyc, wr, errs, or_a, or_b, av3, ak3);
    chk("1x1x1_done_cycle", cyc, 4);
    chk("1x1x1_writes", wr, 1);

    run_dir(1, 1, 1, 0, 0, cyc, wr, errs, or_a, or_b, av3, ak3);
    chk("2x2x2_done_cycle", cyc, 10);
    chk("2x2x2_writes", wr, 4);
    chk("2x2x2_t1_a_vld", 32'(av3), 32'h3);
    chk("2x2x2_t1_a_k", 32'(ak3), 32'h01);
`ifdef MATMUL_SEQ_PERF_CNT_EN
    @(posedge clk); #1;
    chk("2x2x2_perf", 32'(bus.perf_cycles_o), 32'd10);
`endif

    run_dir(3, 3, 3, 0, 0, cyc, wr, errs, or_a, or_b, av3, ak3);
    chk("4x4x4_done_cycle", cyc, 28);
    chk("4x4x4_writes", wr, 16);

    run_dir(2, 1, 3, 0, 0, cyc, wr, errs, or_a, or_b, av3, ak3);
    chk("3x2x4_done_cycle", cyc, 21);
    chk("3x2x4_writes", wr, 12);
    chk("3x2x4_a_vld_union", 32'(or_a), 32'h7);
    chk("3x2x4_b_vld_union", 32'(or_b), 32'hF);

    // Spurious start and operand write during FEED.
    run_dir(1, 1, 1, 3, 4, cyc, wr, errs, or_a, or_b, av3, ak3);
    chk("err_run_done_cycle", cyc, 10);
    chk("err_run_pulses", errs, 2);

    // Reset mid-FEED of a 4x4x4 run.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.dim_n_i = 2'd3; bus.dim_k_i = 2'd3; bus.dim_m_i = 2'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_a_vld", 32'(bus.a_vld_o), 32'd0);
    chk("rst_b_vld", 32'(bus.b_vld_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dones++;
    end
    chk("rst_no_done", dones, 0);

    // Random traffic; every cycle is checked by the model process.
    repeat (1500) begin
      @(posedge clk); #1;
      bus.start_i = ($urandom_range(0, 9) == 0);
      bus.op_wr_i = ($urandom_range(0, 7) == 0);
      bus.dim_n_i = 2'($urandom_range(0, 3));
      bus.dim_k_i = 2'($urandom_range(0, 3));
      bus.dim_m_i = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.op_wr_i = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("final_idle", 32'(bus.busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
